// File: rtl/mem_responder_if.sv
// Command/response bus between the CPU memory controller (master) and mem_responder (slave).
interface mem_responder_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
);
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              mem_ready;
    logic              mem_err;
    logic              busy;

    modport master (
        output mem_cmd, mem_addr, din,
        input  dout, mem_ready, mem_err, busy
    );

    modport slave (
        input  mem_cmd, mem_addr, din,
        output dout, mem_ready, mem_err, busy
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-command responder: word RAM behind a READ/WRITE handshake with programmable wait states.
// Optional switch/LED I/O window enabled by defining MEM_IO_EN.
module mem_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 9,
    parameter int RAM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
`ifdef MEM_IO_EN
    ,
    input  logic [7:0]     sw,
    output logic [7:0]     led
`endif
);
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_WAIT   = 2'b01;
    localparam logic [1:0] ST_RESP   = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    localparam int              RAM_AW      = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [3:0]      WAIT_LOAD   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [1:0]      AFTER_IDLE  = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
    localparam logic [ADDR_W:0] RAM_LIMIT   = (ADDR_W + 1)'(RAM_DEPTH);
`ifdef MEM_IO_EN
    localparam logic [ADDR_W-1:0] SW_ADDR  = ADDR_W'(9'h140);
    localparam logic [ADDR_W-1:0] LED_ADDR = ADDR_W'(9'h100);
`endif

    logic [1:0]        state_r;
    logic [1:0]        next_state_s;
    logic [3:0]        cnt_r;
    logic [1:0]        cmd_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] ram_r [RAM_DEPTH];
    logic [DATA_W-1:0] dout_r;
    logic              ready_r;
    logic              err_r;

    logic              new_cmd_s;
    logic [1:0]        eff_cmd_s;
    logic [ADDR_W-1:0] eff_addr_s;
    logic              is_ram_s;
    logic              mapped_s;
    logic [DATA_W-1:0] rd_data_s;
`ifdef MEM_IO_EN
    logic              is_sw_s;
    logic              is_led_s;
    logic [7:0]        led_r;
`endif

    assign new_cmd_s     = (bus.mem_cmd == CMD_READ) || (bus.mem_cmd == CMD_WRITE);
    assign bus.busy      = (state_r != ST_IDLE);
    assign bus.dout      = dout_r;
    assign bus.mem_ready = ready_r;
    assign bus.mem_err   = err_r;

    // Next-state selection for the IDLE/WAIT/RESP sequencer
    always_comb begin
        next_state_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (new_cmd_s) begin
                    next_state_s = AFTER_IDLE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_RESP: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // With zero wait states the response is formed on the accepting edge, so decode the live bus in IDLE
    always_comb begin
        eff_cmd_s  = (state_r == ST_IDLE) ? bus.mem_cmd  : cmd_r;
        eff_addr_s = (state_r == ST_IDLE) ? bus.mem_addr : addr_r;
        is_ram_s   = ({1'b0, eff_addr_s} < RAM_LIMIT);
`ifdef MEM_IO_EN
        is_sw_s    = !is_ram_s && (eff_addr_s == SW_ADDR)  && (eff_cmd_s == CMD_READ);
        is_led_s   = !is_ram_s && (eff_addr_s == LED_ADDR) && (eff_cmd_s == CMD_WRITE);
        mapped_s   = is_ram_s || is_sw_s || is_led_s;
`else
        mapped_s   = is_ram_s;
`endif
        rd_data_s  = '0;
        if (is_ram_s) begin
            rd_data_s = ram_r[eff_addr_s[RAM_AW-1:0]];
`ifdef MEM_IO_EN
        end else if (is_sw_s) begin
            rd_data_s = {{(DATA_W-8){1'b0}}, sw};
`endif
        end else begin
            rd_data_s = '0;
        end
    end

    // Sequencer state, wait counter and captured command
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            cmd_r   <= 2'b00;
            addr_r  <= '0;
            wdata_r <= '0;
        end else begin
            state_r <= next_state_s;
            if ((state_r == ST_IDLE) && new_cmd_s) begin
                cmd_r   <= bus.mem_cmd;
                addr_r  <= bus.mem_addr;
                wdata_r <= bus.din;
                cnt_r   <= WAIT_LOAD;
            end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end
        end
    end

    // Response outputs are loaded on the edge entering RESP so they are valid throughout it
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_r <= 1'b0;
            err_r   <= 1'b0;
            dout_r  <= '0;
        end else begin
            ready_r <= (next_state_s == ST_RESP);
            err_r   <= (next_state_s == ST_RESP) && !mapped_s;
            if ((next_state_s == ST_RESP) && (eff_cmd_s == CMD_READ)) begin
                dout_r <= rd_data_s;
            end
        end
    end

    // RAM write commits at the end of RESP; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (!reset && (state_r == ST_RESP) && (cmd_r == CMD_WRITE) && is_ram_s) begin
            ram_r[addr_r[RAM_AW-1:0]] <= wdata_r;
        end
    end

`ifdef MEM_IO_EN
    // LED register write at the end of RESP
    always_ff @(posedge clk) begin
        if (reset) begin
            led_r <= 8'h00;
        end else if ((state_r == ST_RESP) && is_led_s) begin
            led_r <= wdata_r[7:0];
        end
    end

    assign led = led_r;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one-wait-state instance checked every cycle against a
// transaction-level model, plus a zero-wait-state instance for back-to-back throughput.
`timescale 1ns/1ps
module tb_mem_responder;
    localparam int DW = 16;
    localparam int AW = 9;
    localparam int WA = 1;
    localparam int WB = 0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
    mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();
`ifdef MEM_IO_EN
    logic [7:0] sw_a, led_a, sw_b, led_b;
`endif

    mem_responder #(.DATA_W(DW), .ADDR_W(AW), .RAM_DEPTH(256), .WAIT_CYCLES(WA)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave)
`ifdef MEM_IO_EN
        , .sw(sw_a), .led(led_a)
`endif
    );

    mem_responder #(.DATA_W(DW), .ADDR_W(AW), .RAM_DEPTH(256), .WAIT_CYCLES(WB)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave)
`ifdef MEM_IO_EN
        , .sw(sw_b), .led(led_b)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model of dut_a: each accepted command responds WA edges later and frees
    // the responder one edge after that; writes land in an associative memory when freed.
    int          k = 0;
    bit          pend = 1'b0;
    int          resp_edge = 0;
    logic [1:0]  p_cmd;
    logic [8:0]  p_addr;
    logic [15:0] p_data;
    logic        m_ready = 1'b0, m_err = 1'b0;
    logic [15:0] m_dout = 16'h0000;
    logic [7:0]  m_led = 8'h00;
    logic [15:0] mmem [int];
    bit          chk_en = 1'b0;

    function automatic bit m_mapped(input logic [1:0] cmd, input logic [8:0] addr);
        bit m;
        m = (addr < 9'd256);
`ifdef MEM_IO_EN
        m = m || (cmd == 2'b01 && addr == 9'h140) || (cmd == 2'b10 && addr == 9'h100);
`endif
        return m;
    endfunction

    initial forever begin
        @(posedge clk);
        k++;
        if (reset) begin
            pend = 1'b0; m_ready = 1'b0; m_err = 1'b0; m_dout = 16'h0000; m_led = 8'h00;
        end else begin
            m_ready = 1'b0;
            m_err   = 1'b0;
            if (pend && k == resp_edge + 1) begin
                if (p_cmd == 2'b10) begin
                    if (p_addr < 9'd256) mmem[int'(p_addr)] = p_data;
`ifdef MEM_IO_EN
                    else if (p_addr == 9'h100) m_led = p_data[7:0];
`endif
                end
                pend = 1'b0;
            end else if (!pend && (bus_a.mem_cmd == 2'b01 || bus_a.mem_cmd == 2'b10)) begin
                pend = 1'b1; p_cmd = bus_a.mem_cmd; p_addr = bus_a.mem_addr; p_data = bus_a.din;
                resp_edge = k + WA;
            end
            if (pend && k == resp_edge) begin
                m_ready = 1'b1;
                m_err   = !m_mapped(p_cmd, p_addr);
                if (p_cmd == 2'b01) begin
                    if (p_addr < 9'd256 && mmem.exists(int'(p_addr))) m_dout = mmem[int'(p_addr)];
`ifdef MEM_IO_EN
                    else if (p_addr == 9'h140) m_dout = {8'h00, sw_a};
`endif
                    else m_dout = 16'h0000;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of dut_a against the model
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("a_ready", bus_a.mem_ready, m_ready);
            check("a_err",   bus_a.mem_err,   m_err);
            check("a_busy",  bus_a.busy,      pend);
            check("a_dout",  bus_a.dout,      m_dout);
`ifdef MEM_IO_EN
            check("a_led",   led_a,           m_led);
`endif
        end
    end

    // Issue one command, wait (bounded) for mem_ready, then drop the command; gap adds one idle cycle
    task automatic do_txn(input bit sel, input logic [1:0] cmd, input logic [8:0] addr,
                          input logic [15:0] data, input bit gap,
                          output logic [15:0] rd, output logic err, output int lat, output int rk);
        int  start;
        bit  seen;
        start = k; seen = 1'b0; lat = -1; rk = -1; rd = 16'h0000; err = 1'b0;
        if (sel) begin
            bus_b.mem_cmd = cmd; bus_b.mem_addr = addr; bus_b.din = data;
        end else begin
            bus_a.mem_cmd = cmd; bus_a.mem_addr = addr; bus_a.din = data;
        end
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if ((sel ? bus_b.mem_ready : bus_a.mem_ready) === 1'b1) begin
                seen = 1'b1; lat = k - start; rk = k;
                rd  = sel ? bus_b.dout    : bus_a.dout;
                err = sel ? bus_b.mem_err : bus_a.mem_err;
            end
        end
        if (sel) bus_b.mem_cmd = 2'b00; else bus_a.mem_cmd = 2'b00;
        check("ready_seen", seen, 1'b1);
        if (gap) @(negedge clk);
    endtask

    logic [15:0] rd;
    logic        er;
    int          lat, rk0, rk1;

    initial begin
        reset = 1'b1;
        bus_a.mem_cmd = 2'b00; bus_a.mem_addr = 9'h000; bus_a.din = 16'h0000;
        bus_b.mem_cmd = 2'b00; bus_b.mem_addr = 9'h000; bus_b.din = 16'h0000;
`ifdef MEM_IO_EN
        sw_a = 8'h5A; sw_b = 8'h00;
`endif
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_dout",  bus_a.dout,      16'h0000);
        check("rst_ready", bus_a.mem_ready, 1'b0);
        check("rst_busy",  bus_a.busy,      1'b0);
        check("rst_err",   bus_a.mem_err,   1'b0);
        reset = 1'b0;
        @(negedge clk);

        do_txn(1'b0, 2'b10, 9'h005, 16'hABCD, 1'b1, rd, er, lat, rk0);
        check("wr005_lat", lat, 32'd2);
        check("wr005_err", er, 1'b0);
        do_txn(1'b0, 2'b01, 9'h005, 16'h0000, 1'b1, rd, er, lat, rk0);
        check("rd005_lat", lat, 32'd2);
        check("rd005_dout", rd, 16'hABCD);
        check("rd005_err", er, 1'b0);

        do_txn(1'b0, 2'b10, 9'h010, 16'h3C3C, 1'b0, rd, er, lat, rk0);
        do_txn(1'b0, 2'b10, 9'h0F0, 16'h7777, 1'b0, rd, er, lat, rk0);
        do_txn(1'b0, 2'b01, 9'h010, 16'h0000, 1'b1, rd, er, lat, rk0);
        check("rd010_dout", rd, 16'h3C3C);

        do_txn(1'b0, 2'b10, 9'h1F0, 16'h5555, 1'b1, rd, er, lat, rk0);
        check("wr1f0_err", er, 1'b1);
        do_txn(1'b0, 2'b01, 9'h1F0, 16'h0000, 1'b1, rd, er, lat, rk0);
        check("rd1f0_dout", rd, 16'h0000);
        check("rd1f0_err", er, 1'b1);
        do_txn(1'b0, 2'b01, 9'h0F0, 16'h0000, 1'b1, rd, er, lat, rk0);
        check("rd0f0_dout", rd, 16'h7777);

        // Reset during the wait state of a WRITE
        bus_a.mem_cmd = 2'b10; bus_a.mem_addr = 9'h010; bus_a.din = 16'hFFFF;
        @(negedge clk);
        check("midwr_busy", bus_a.busy, 1'b1);
        reset = 1'b1; bus_a.mem_cmd = 2'b00;
        @(negedge clk);
        check("midrst_ready", bus_a.mem_ready, 1'b0);
        check("midrst_busy",  bus_a.busy,      1'b0);
        check("midrst_dout",  bus_a.dout,      16'h0000);
        reset = 1'b0;
        @(negedge clk);
        do_txn(1'b0, 2'b01, 9'h010, 16'h0000, 1'b1, rd, er, lat, rk0);
        check("rd010_after_rst", rd, 16'h3C3C);

        bus_a.mem_cmd = 2'b11; bus_a.mem_addr = 9'h005;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("cmd11_busy",  bus_a.busy,      1'b0);
            check("cmd11_ready", bus_a.mem_ready, 1'b0);
        end
        bus_a.mem_cmd = 2'b00;
        @(negedge clk);

`ifdef MEM_IO_EN
        do_txn(1'b0, 2'b01, 9'h140, 16'h0000, 1'b1, rd, er, lat, rk0);
        check("rd140_dout", rd, 16'h005A);
        check("rd140_err", er, 1'b0);
        do_txn(1'b0, 2'b10, 9'h100, 16'h12C3, 1'b1, rd, er, lat, rk0);
        check("wr100_led", led_a, 8'hC3);
        check("wr100_err", er, 1'b0);
`else
        do_txn(1'b0, 2'b01, 9'h140, 16'h0000, 1'b1, rd, er, lat, rk0);
        check("rd140_dout", rd, 16'h0000);
        check("rd140_err", er, 1'b1);
`endif

        // Zero-wait-state instance: preload, then back-to-back reads
        do_txn(1'b1, 2'b10, 9'h000, 16'h1111, 1'b1, rd, er, lat, rk0);
        check("b_wr_lat", lat, 32'd1);
        do_txn(1'b1, 2'b10, 9'h0FF, 16'h2222, 1'b1, rd, er, lat, rk0);
        do_txn(1'b1, 2'b01, 9'h000, 16'h0000, 1'b0, rd, er, lat, rk0);
        check("b_rd000_dout", rd, 16'h1111);
        do_txn(1'b1, 2'b01, 9'h0FF, 16'h0000, 1'b0, rd, er, lat, rk1);
        check("b_rd0ff_dout", rd, 16'h2222);
        check("b_ready_spacing", rk1 - rk0, 32'd2);
        check("b_rd0ff_err", er, 1'b0);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
